// File: rtl/m8_deframer_pkg.sv
// m8_deframer_pkg: constants and lock-state encoding shared by the
// Orbita M8 former, deframer and memory wrappers.
package m8_deframer_pkg;

  localparam int WORD_W = 12;
  localparam int ADDR_W = 10;
  localparam int ECNT_W = 8;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic [ECNT_W-1:0] sat_inc(
    input logic [ECNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/m8_deframer_if.sv
// m8_deframer_if: serial Orbita stream in (iSerial, iValid) and the
// deframed word bus out (oData/oAddr/oWren, status and error outputs).
interface m8_deframer_if;
  import m8_deframer_pkg::*;

  logic              iSerial;
  logic              iValid;
  logic [WORD_W-1:0] oData;
  logic [ADDR_W-1:0] oAddr;
  logic              oWren;
  logic              oFrameStart;
  logic              oLocked;
  logic              oBitErr;
  logic [ECNT_W-1:0] oErrCnt;

  modport master (
    output iSerial, iValid,
    input  oData, oAddr, oWren, oFrameStart,
    input  oLocked, oBitErr, oErrCnt
  );

  modport slave (
    input  iSerial, iValid,
    output oData, oAddr, oWren, oFrameStart,
    output oLocked, oBitErr, oErrCnt
  );

endinterface

// File: rtl/m8_word_deser.sv
// m8_word_deser: shifts in the MSB-first serial stream and checks word
// spacing. Ports: clk, reset, serial, valid -> word, word_stb, bit_err.
module m8_word_deser
  import m8_deframer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              serial,
  input  logic              valid,
  output logic [WORD_W-1:0] word,
  output logic              word_stb,
  output logic              bit_err
);

  localparam logic [3:0] GAP = 4'(WORD_W - 1);

  logic [WORD_W-2:0] shreg;
  logic [3:0]        cnt;
  logic              synced;
  logic              aligned;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg  <= '0;
      cnt    <= '0;
      synced <= 1'b0;
    end else begin
      shreg <= {shreg[WORD_W-3:0], serial};
      if (valid) begin
        synced <= 1'b1;
        cnt    <= '0;
      end else if (cnt != 4'hF) begin
        // saturate so a long gap never aliases to a good one
        cnt <= cnt + 4'd1;
      end
    end
  end

  assign aligned  = (cnt == GAP);
  assign word     = {shreg, serial};
  // the first strobe after reset only starts the gap counter
  assign word_stb = valid & synced & aligned;
  assign bit_err  = valid & synced & ~aligned;

endmodule

// File: rtl/m8_deframer.sv
// m8_deframer: word deserialiser plus sync-lock FSM. Ports: clk, reset,
// bus (slave): iSerial/iValid in; oData/oAddr/oWren and status out.
module m8_deframer
  import m8_deframer_pkg::*;
#(
  parameter int              WORDS     = 1024,
  parameter logic [WORD_W-1:0] SYNC_WORD = 12'hE1C,
  parameter int              LOCK_CNT  = 3,
  parameter int              MISS_CNT  = 2
) (
  input logic           clk,
  input logic           reset,
  m8_deframer_if.slave  bus
);

  localparam logic [2:0]        LC   = 3'(LOCK_CNT);
  localparam logic [2:0]        MC   = 3'(MISS_CNT);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);

  logic [WORD_W-1:0] word;
  logic              word_stb;
  logic              bit_err;

  m8_word_deser u_deser (
    .clk      (clk),
    .reset    (reset),
    .serial   (bus.iSerial),
    .valid    (bus.iValid),
    .word     (word),
    .word_stb (word_stb),
    .bit_err  (bit_err)
  );

  state_t            state;
  logic [ADDR_W-1:0] pos;
  logic [ADDR_W-1:0] pos_next;
  logic [2:0]        conf;
  logic [2:0]        miss;
  logic              is_sync;
  logic              at_zero;

  logic [WORD_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic              wren;
  logic              fstart;
  logic              locked;
  logic              berr;
  logic [ECNT_W-1:0] ecnt;

  assign is_sync  = (word == SYNC_WORD);
  assign at_zero  = (pos == '0);
  assign pos_next = (pos == LAST) ? '0 : pos + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= HUNT;
      pos    <= '0;
      conf   <= '0;
      miss   <= '0;
      data   <= '0;
      addr   <= '0;
      wren   <= 1'b0;
      fstart <= 1'b0;
      locked <= 1'b0;
      berr   <= 1'b0;
      ecnt   <= '0;
    end else begin
      wren   <= 1'b0;
      fstart <= 1'b0;
      berr   <= 1'b0;
      if (bit_err) begin
        // slip outranks any sync check on the same word
        berr   <= 1'b1;
        ecnt   <= sat_inc(ecnt);
        state  <= HUNT;
        locked <= 1'b0;
        conf   <= '0;
        miss   <= '0;
      end else if (word_stb) begin
        pos <= pos_next;
        unique case (state)
          HUNT: begin
            if (is_sync) begin
              pos  <= ADDR_W'(1);
              conf <= 3'd1;
              if (LC == 3'd1) begin
                state  <= LOCKED;
                miss   <= '0;
                locked <= 1'b1;
                wren   <= 1'b1;
                fstart <= 1'b1;
                data   <= word;
                addr   <= '0;
              end else begin
                state <= VERIFY;
              end
            end
          end
          VERIFY: begin
            if (at_zero) begin
              if (!is_sync) begin
                state <= HUNT;
              end else begin
                conf <= conf + 3'd1;
                if (conf + 3'd1 == LC) begin
                  state  <= LOCKED;
                  miss   <= '0;
                  locked <= 1'b1;
                  wren   <= 1'b1;
                  fstart <= 1'b1;
                  data   <= word;
                  addr   <= pos;
                end
              end
            end
          end
          LOCKED: begin
            if (at_zero && !is_sync && miss + 3'd1 == MC) begin
              state  <= HUNT;
              locked <= 1'b0;
              miss   <= '0;
              ecnt   <= sat_inc(ecnt);
            end else begin
              if (at_zero) begin
                miss <= is_sync ? 3'd0 : miss + 3'd1;
                if (!is_sync) ecnt <= sat_inc(ecnt);
              end
              wren   <= 1'b1;
              fstart <= at_zero;
              data   <= word;
              addr   <= pos;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  assign bus.oData       = data;
  assign bus.oAddr       = addr;
  assign bus.oWren       = wren;
  assign bus.oFrameStart = fstart;
  assign bus.oLocked     = locked;
  assign bus.oBitErr     = berr;
  assign bus.oErrCnt     = ecnt;

endmodule

// File: tb/tb_m8_deframer.sv
// tb_m8_deframer: directed stream bench for m8_deframer with short
// 16-word frames: lock, wrap, misses, false sync, slip, reset, saturation.
module tb_m8_deframer;
  import m8_deframer_pkg::*;

  localparam int          NW   = 16;
  localparam logic [11:0] SYNC = 12'hE1C;

  logic clk = 1'b0;
  logic reset;

  m8_deframer_if bus ();

  m8_deframer #(
    .WORDS     (NW),
    .SYNC_WORD (SYNC),
    .LOCK_CNT  (3),
    .MISS_CNT  (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int stray = 0;
  int nwr   = 0;

  logic        s_wr, s_fs, s_lk, s_be;
  logic [11:0] s_data;
  logic [9:0]  s_addr;
  logic [7:0]  s_ec;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ramp(input int f, input int p);
    return (p == 0) ? SYNC : 12'((f * NW + p) & 'h7FF);
  endfunction

  // one word, MSB first, optionally preceded by slip bits;
  // samples the registered result 1 time unit after the capture edge
  task automatic send_word(input logic [11:0] w, input int extra);
    for (int c = 0; c < 12 + extra; c++) begin
      @(negedge clk);
      if (c > 0)
        stray += int'(bus.oWren | bus.oBitErr | bus.oFrameStart);
      bus.iSerial = (c < extra) ? 1'b0 : w[11 - (c - extra)];
      bus.iValid  = (c == 11 + extra);
    end
    @(posedge clk);
    #1;
    s_wr   = bus.oWren;
    s_fs   = bus.oFrameStart;
    s_lk   = bus.oLocked;
    s_be   = bus.oBitErr;
    s_data = bus.oData;
    s_addr = bus.oAddr;
    s_ec   = bus.oErrCnt;
    nwr   += int'(bus.oWren);
  endtask

  task automatic expect_w(input string tag, input logic wr,
                          input logic [9:0] a, input logic [11:0] d,
                          input logic fs, input logic lk);
    chk({tag, ".wr"}, 32'(s_wr), 32'(wr));
    chk({tag, ".lk"}, 32'(s_lk), 32'(lk));
    if (wr) begin
      chk({tag, ".addr"}, 32'(s_addr), 32'(a));
      chk({tag, ".data"}, 32'(s_data), 32'(d));
      chk({tag, ".fs"}, 32'(s_fs), 32'(fs));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".data"}, 32'(bus.oData), 0);
    chk({tag, ".addr"}, 32'(bus.oAddr), 0);
    chk({tag, ".wr"}, 32'(bus.oWren), 0);
    chk({tag, ".fs"}, 32'(bus.oFrameStart), 0);
    chk({tag, ".lk"}, 32'(bus.oLocked), 0);
    chk({tag, ".be"}, 32'(bus.oBitErr), 0);
    chk({tag, ".ec"}, 32'(bus.oErrCnt), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset       = 1'b1;
    bus.iSerial = 1'b0;
    bus.iValid  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("rst");
    reset = 1'b0;

    send_word(12'hABC, 0);
    chk("first.be", 32'(s_be), 0);
    chk("first.wr", 32'(s_wr), 0);

    for (int f = 0; f < 2; f++)
      for (int p = 0; p < NW; p++) begin
        send_word(ramp(f, p), 0);
        if (p == 0) chk("verify.lk", 32'(s_lk), 0);
      end
    send_word(ramp(2, 0), 0);
    expect_w("lock", 1'b1, 10'd0, SYNC, 1'b1, 1'b1);
    chk("lock.nwr", 32'(nwr), 1);

    for (int f = 2; f < 4; f++)
      for (int p = (f == 2) ? 1 : 0; p < NW; p++) begin
        send_word(ramp(f, p), 0);
        expect_w("ramp", 1'b1, 10'(p), ramp(f, p), p == 0, 1'b1);
      end
    chk("ramp.stray", 32'(stray), 0);

    send_word(12'h000, 0);
    expect_w("miss1", 1'b1, 10'd0, 12'h000, 1'b1, 1'b1);
    chk("miss1.ec", 32'(s_ec), 1);
    for (int p = 1; p < NW; p++) send_word(ramp(4, p), 0);
    expect_w("miss1.hold", 1'b1, 10'(NW - 1), ramp(4, NW - 1),
             1'b0, 1'b1);
    send_word(12'h001, 0);
    expect_w("miss2", 1'b0, 10'd0, 12'h000, 1'b0, 1'b0);
    chk("miss2.ec", 32'(s_ec), 2);

    nwr = 0;
    for (int p = 1; p < NW; p++)
      send_word((p == 5) ? SYNC : ramp(5, p), 0);
    for (int f = 6; f < 9; f++)
      for (int p = 0; p < NW; p++) begin
        send_word(ramp(f, p), 0);
        if (f == 8 && p == 0) chk("false.lk", 32'(s_lk), 0);
      end
    chk("false.nwr", 32'(nwr), 0);
    send_word(ramp(9, 0), 0);
    expect_w("relock", 1'b1, 10'd0, SYNC, 1'b1, 1'b1);

    for (int p = 1; p < 10; p++) send_word(ramp(9, p), 0);
    expect_w("preslip", 1'b1, 10'd9, ramp(9, 9), 1'b0, 1'b1);
    send_word(ramp(9, 10), 1);
    expect_w("slip", 1'b0, 10'd0, 12'h000, 1'b0, 1'b0);
    chk("slip.be", 32'(s_be), 1);
    chk("slip.ec", 32'(s_ec), 3);

    nwr   = 0;
    stray = 0;
    for (int p = 11; p < NW; p++) send_word(ramp(9, p), 0);
    for (int f = 10; f < 12; f++)
      for (int p = 0; p < NW; p++) begin
        send_word(ramp(f, p), 0);
        if (f == 11 && p == 0) chk("slip.relk", 32'(s_lk), 0);
      end
    chk("slip.nwr", 32'(nwr), 0);
    send_word(ramp(12, 0), 0);
    expect_w("relock2", 1'b1, 10'd0, SYNC, 1'b1, 1'b1);
    chk("relock2.stray", 32'(stray), 0);

    for (int p = 1; p < 5; p++) send_word(ramp(12, p), 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.iSerial = 1'b1;
      bus.iValid  = 1'b0;
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("midrst");
    @(negedge clk);
    reset = 1'b0;

    send_word(SYNC, 0);
    chk("post.be", 32'(s_be), 0);
    chk("post.wr", 32'(s_wr), 0);
    send_word(SYNC, 0);
    chk("post2.be", 32'(s_be), 0);
    chk("post2.wr", 32'(s_wr), 0);

    for (int i = 0; i < 300; i++) begin
      send_word(12'h123, 1);
      if (i == 0) chk("sat.first", 32'(s_ec), 1);
      if (i == 253) chk("sat.254", 32'(s_ec), 254);
      if (i == 254) chk("sat.255", 32'(s_ec), 255);
    end
    chk("sat.ec", 32'(s_ec), 255);
    chk("sat.be", 32'(s_be), 1);
    chk("sat.lk", 32'(s_lk), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
